// File: rtl/loopyV_data_types.sv
// Shared pipeline types: funct3 load/store width codes and the LSU state enum.
package loopyV_data_types;

  localparam logic [2:0] FUNCT3_BYTE   = 3'b000;
  localparam logic [2:0] FUNCT3_HALF   = 3'b001;
  localparam logic [2:0] FUNCT3_WORD   = 3'b010;
  localparam logic [2:0] FUNCT3_BYTE_U = 3'b100;
  localparam logic [2:0] FUNCT3_HALF_U = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_WAIT,
    LSU_DONE
  } lsu_state_e;

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory request/grant/response port between the LSU (master) and memory (slave).
interface load_store_unit_if;
  logic        dmemReq;
  logic        dmemWe;
  logic [31:0] dmemAddr;
  logic [3:0]  dmemBe;
  logic [31:0] dmemWdata;
  logic        dmemGnt;
  logic        dmemRvalid;
  logic [31:0] dmemRdata;

  modport master (
    output dmemReq, dmemWe, dmemAddr, dmemBe, dmemWdata,
    input  dmemGnt, dmemRvalid, dmemRdata
  );

  modport slave (
    input  dmemReq, dmemWe, dmemAddr, dmemBe, dmemWdata,
    output dmemGnt, dmemRvalid, dmemRdata
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store byte enables/replication, load extraction
// with sign/zero extension, and misalignment detection.
module lsu_align
  import loopyV_data_types::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);
  logic [1:0]  eff_off;
  logic [31:0] shifted;

  always_comb begin
    eff_off    = 2'b00;
    be         = 4'b1111;
    wdata      = store_data;
    misaligned = 1'b0;
    // Halfwords drop address[0] and words drop address[1:0] when not trapping.
    case (funct3)
      FUNCT3_BYTE, FUNCT3_BYTE_U: begin
        eff_off = offset;
        be      = 4'b0001 << offset;
        wdata   = {4{store_data[7:0]}};
      end
      FUNCT3_HALF, FUNCT3_HALF_U: begin
        eff_off    = {offset[1], 1'b0};
        be         = 4'b0011 << eff_off;
        wdata      = {2{store_data[15:0]}};
        misaligned = offset[0];
      end
      default: misaligned = |offset;
    endcase

    shifted = rdata >> {eff_off, 3'b000};
    case (funct3)
      FUNCT3_BYTE:   load_data = {{24{shifted[7]}}, shifted[7:0]};
      FUNCT3_BYTE_U: load_data = {24'h0, shifted[7:0]};
      FUNCT3_HALF:   load_data = {{16{shifted[15]}}, shifted[15:0]};
      FUNCT3_HALF_U: load_data = {16'h0, shifted[15:0]};
      default:       load_data = shifted;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: IDLE/REQ/WAIT/DONE access sequencer with upstream stall.
// Define LSU_MISALIGNED_TRAP_EN to fault misaligned H/W accesses instead of issuing them.
module load_store_unit
  import loopyV_data_types::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              exValid,
  input  logic              loadSignal,
  input  logic              storeSignal,
  input  logic [2:0]        loadStoreByteSelect,
  input  logic [31:0]       address,
  input  logic [31:0]       storeData,
  input  logic [4:0]        rdAddr,
  input  logic              rdWriteEn,
  output logic              stall,
  load_store_unit_if.master dmem,
  output logic              wbValid,
  output logic [4:0]        wbRdAddr,
  output logic [31:0]       wbData,
  output logic              wbWriteEn,
  output logic              misalignedFault
);
  lsu_state_e  state_q, state_d;
  logic        req_q, req_d, we_q, we_d, is_load_q, is_load_d, rd_we_q, rd_we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, wb_data_q, wb_data_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  funct3_q, funct3_d, sel_funct3;
  logic [1:0]  offset_q, offset_d, sel_offset;
  logic [4:0]  rd_addr_q, rd_addr_d, wb_rd_addr_q, wb_rd_addr_d;
  logic        wb_valid_q, wb_valid_d, wb_we_q, wb_we_d, fault_q, fault_d;
  logic        mem_op, in_idle;
  logic [3:0]  align_be;
  logic [31:0] align_wdata, align_load;
  logic        align_misaligned;

  assign in_idle = (state_q == LSU_IDLE);
  assign mem_op  = exValid & (loadSignal | storeSignal);

  // In IDLE the aligner formats the incoming store; afterwards it formats the load response.
  assign sel_funct3 = in_idle ? loadStoreByteSelect : funct3_q;
  assign sel_offset = in_idle ? address[1:0]        : offset_q;

  lsu_align u_align (
    .funct3     (sel_funct3),
    .offset     (sel_offset),
    .store_data (storeData),
    .rdata      (dmem.dmemRdata),
    .be         (align_be),
    .wdata      (align_wdata),
    .load_data  (align_load),
    .misaligned (align_misaligned)
  );

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    is_load_d    = is_load_q;
    funct3_d     = funct3_q;
    offset_d     = offset_q;
    rd_addr_d    = rd_addr_q;
    rd_we_d      = rd_we_q;
    wb_data_d    = wb_data_q;
    wb_rd_addr_d = wb_rd_addr_q;
    wb_valid_d   = 1'b0;
    wb_we_d      = 1'b0;
    fault_d      = 1'b0;
    stall        = 1'b0;
    case (state_q)
      LSU_IDLE: if (mem_op) begin
        stall     = 1'b1;
        is_load_d = loadSignal;
        funct3_d  = loadStoreByteSelect;
        offset_d  = address[1:0];
        rd_addr_d = rdAddr;
        rd_we_d   = rdWriteEn;
`ifdef LSU_MISALIGNED_TRAP_EN
        if (align_misaligned) begin
          state_d = LSU_DONE;
          fault_d = 1'b1;
        end else
`endif
        begin
          state_d = LSU_REQ;
          req_d   = 1'b1;
          we_d    = ~loadSignal;
          addr_d  = {address[31:2], 2'b00};
          be_d    = align_be;
          wdata_d = align_wdata;
        end
      end
      LSU_REQ: begin
        stall = 1'b1;
        if (dmem.dmemGnt) begin
          req_d   = 1'b0;
          state_d = is_load_q ? LSU_WAIT : LSU_DONE;
        end
      end
      LSU_WAIT: begin
        stall = 1'b1;
        if (dmem.dmemRvalid) begin
          wb_data_d    = align_load;
          wb_rd_addr_d = rd_addr_q;
          wb_valid_d   = 1'b1;
          wb_we_d      = rd_we_q;
          state_d      = LSU_DONE;
        end
      end
      LSU_DONE: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LSU_IDLE;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      is_load_q    <= 1'b0;
      funct3_q     <= '0;
      offset_q     <= '0;
      rd_addr_q    <= '0;
      rd_we_q      <= 1'b0;
      wb_data_q    <= '0;
      wb_rd_addr_q <= '0;
      wb_valid_q   <= 1'b0;
      wb_we_q      <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      is_load_q    <= is_load_d;
      funct3_q     <= funct3_d;
      offset_q     <= offset_d;
      rd_addr_q    <= rd_addr_d;
      rd_we_q      <= rd_we_d;
      wb_data_q    <= wb_data_d;
      wb_rd_addr_q <= wb_rd_addr_d;
      wb_valid_q   <= wb_valid_d;
      wb_we_q      <= wb_we_d;
      fault_q      <= fault_d;
    end
  end

  assign dmem.dmemReq   = req_q;
  assign dmem.dmemWe    = we_q;
  assign dmem.dmemAddr  = addr_q;
  assign dmem.dmemBe    = be_q;
  assign dmem.dmemWdata = wdata_q;
  assign wbValid        = wb_valid_q;
  assign wbRdAddr       = wb_rd_addr_q;
  assign wbData         = wb_data_q;
  assign wbWriteEn      = wb_we_q;

`ifdef LSU_MISALIGNED_TRAP_EN
  assign misalignedFault = fault_q;
`else
  logic unused_fault;
  assign unused_fault    = align_misaligned | fault_q;
  assign misalignedFault = 1'b0;
`endif
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a memory model grants/responds, a monitor
// pops expected bus requests, writebacks and faults as the DUT produces them.
module tb_load_store_unit;
  logic        clk, rst, exValid, loadSignal, storeSignal, rdWriteEn;
  logic [2:0]  loadStoreByteSelect;
  logic [31:0] address, storeData;
  logic [4:0]  rdAddr;
  logic        stall, wbValid, wbWriteEn, misalignedFault;
  logic [4:0]  wbRdAddr;
  logic [31:0] wbData;

  load_store_unit_if dmem_bus();

  load_store_unit dut (
    .clk(clk), .rst(rst), .exValid(exValid), .loadSignal(loadSignal),
    .storeSignal(storeSignal), .loadStoreByteSelect(loadStoreByteSelect),
    .address(address), .storeData(storeData), .rdAddr(rdAddr), .rdWriteEn(rdWriteEn),
    .stall(stall), .dmem(dmem_bus), .wbValid(wbValid), .wbRdAddr(wbRdAddr),
    .wbData(wbData), .wbWriteEn(wbWriteEn), .misalignedFault(misalignedFault)
  );

  typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } req_t;
  typedef struct { logic [4:0] rd; logic [31:0] data; logic we; } wb_t;

  req_t        exp_req[$];
  wb_t         exp_wb[$];
  int          flt_n = 0;
  int          n_cmp = 0, n_err = 0;
  int          gnt_dly = 0, rv_dly = 0, req_cnt = 0, rv_cnt = 0, req_cycles = 0;
  bit          rv_pend = 1'b0;
  logic [31:0] rd_word = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    be = 4'b0000;
    case (f3)
      3'b000, 3'b100: be[off] = 1'b1;
      3'b001, 3'b101: begin be[{off[1], 1'b0}] = 1'b1; be[{off[1], 1'b1}] = 1'b1; end
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
    case (f3)
      3'b000: return {4{sd[7:0]}};
      3'b001: return {2{sd[15:0]}};
      default: return sd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
    logic [7:0]  by [4];
    logic [15:0] h;
    for (int i = 0; i < 4; i++) by[i] = w[8*i +: 8];
    h = {by[{off[1], 1'b1}], by[{off[1], 1'b0}]};
    case (f3)
      3'b000: return {{24{by[off][7]}}, by[off]};
      3'b100: return {24'h0, by[off]};
      3'b001: return {{16{h[15]}}, h};
      3'b101: return {16'h0, h};
      default: return w;
    endcase
  endfunction

  // Memory model and output monitor share one negedge process.
  always @(negedge clk) begin
    req_t r;
    wb_t  w;
    dmem_bus.dmemGnt    = 1'b0;
    dmem_bus.dmemRvalid = 1'b0;
    if (rv_pend) begin
      if (rv_cnt == 0) begin
        dmem_bus.dmemRvalid = 1'b1;
        dmem_bus.dmemRdata  = rd_word;
        rv_pend             = 1'b0;
      end else rv_cnt = rv_cnt - 1;
    end
    if (dmem_bus.dmemReq) begin
      req_cycles++;
      if (req_cnt >= gnt_dly) begin
        dmem_bus.dmemGnt = 1'b1;
        req_cnt = 0;
        if (exp_req.size() == 0) chk("req_unexpected", 1, 0);
        else begin
          r = exp_req.pop_front();
          chk("req_we", dmem_bus.dmemWe, r.we);
          chk("req_addr", dmem_bus.dmemAddr, r.addr);
          chk("req_be", dmem_bus.dmemBe, r.be);
          if (r.we) chk("req_wdata", dmem_bus.dmemWdata, r.wdata);
        end
        if (!dmem_bus.dmemWe) begin rv_pend = 1'b1; rv_cnt = rv_dly; end
      end else req_cnt++;
    end
    if (wbValid) begin
      if (exp_wb.size() == 0) chk("wb_unexpected", 1, 0);
      else begin
        w = exp_wb.pop_front();
        chk("wb_data", wbData, w.data);
        chk("wb_rd", wbRdAddr, w.rd);
        chk("wb_we", wbWriteEn, w.we);
      end
    end
    if (misalignedFault) begin
      chk("fault_expected", (flt_n > 0), 1);
      if (flt_n > 0) flt_n--;
    end
  end

  // Presents one instruction at posedge+1 and holds it until stall drops (end of DONE).
  task automatic do_op(input string tag, input bit ld, input bit st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd,
                       input bit rwe, input int gd, input int rvd, input logic [31:0] word);
    req_t r;
    wb_t  w;
    bit   mem, mis;
    int   exp_stall, exp_rc, n;
    mem = ld | st;
    mis = 1'b0;
`ifdef LSU_MISALIGNED_TRAP_EN
    mis = ((f3 == 3'b001 || f3 == 3'b101) && a[0]) || (f3 == 3'b010 && a[1:0] != 2'b00);
`endif
    exp_stall = 0;
    exp_rc    = 0;
    if (mem && mis) begin
      exp_stall = 1;
      flt_n++;
    end else if (mem) begin
      r.we = !ld; r.addr = {a[31:2], 2'b00}; r.be = m_be(f3, a[1:0]); r.wdata = m_wdata(f3, sd);
      exp_req.push_back(r);
      exp_rc    = gd + 1;
      exp_stall = ld ? gd + rvd + 3 : gd + 2;
      if (ld) begin
        w.rd = rd; w.data = m_load(f3, a[1:0], word); w.we = rwe;
        exp_wb.push_back(w);
      end
    end
    gnt_dly = gd; rv_dly = rvd; rd_word = word; req_cycles = 0;
    exValid = 1'b1; loadSignal = ld; storeSignal = st; loadStoreByteSelect = f3;
    address = a; storeData = sd; rdAddr = rd; rdWriteEn = rwe;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!stall) break;
      n++;
    end
    if (n >= 64) chk({tag, "_stall_timeout"}, 1, 0);
    @(posedge clk); #1;
    exValid = 1'b0;
    chk({tag, "_stall_cycles"}, n, exp_stall);
    chk({tag, "_req_cycles"}, req_cycles, exp_rc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; exValid = 1'b0; loadSignal = 1'b0; storeSignal = 1'b0;
    loadStoreByteSelect = 3'b000; address = '0; storeData = '0; rdAddr = '0; rdWriteEn = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_req", dmem_bus.dmemReq, 0);
    chk("rst_we", dmem_bus.dmemWe, 0);
    chk("rst_addr", dmem_bus.dmemAddr, 0);
    chk("rst_be", dmem_bus.dmemBe, 0);
    chk("rst_wdata", dmem_bus.dmemWdata, 0);
    chk("rst_wbvalid", wbValid, 0);
    chk("rst_wbwe", wbWriteEn, 0);
    chk("rst_wbdata", wbData, 0);
    chk("rst_wbrd", wbRdAddr, 0);
    chk("rst_fault", misalignedFault, 0);
    chk("rst_stall", stall, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op("sb",   0, 1, 3'b000, 32'h0000_1003, 32'hAABB_CCDD, 5'd0,  0, 0, 0, 32'h0);
    do_op("lb",   1, 0, 3'b000, 32'h0000_2001, 32'h0,         5'd5,  1, 0, 0, 32'h1234_8056);
    do_op("lhu",  1, 0, 3'b101, 32'h0000_2002, 32'h0,         5'd9,  1, 3, 1, 32'h8001_FFFF);
    do_op("sh",   0, 1, 3'b001, 32'h0000_1006, 32'h1122_3344, 5'd0,  0, 1, 0, 32'h0);
    chk("wbdata_hold", wbData, 32'h0000_8001);
    do_op("lw_mis", 1, 0, 3'b010, 32'h0000_3002, 32'h0,       5'd7,  1, 0, 0, 32'hCAFE_F00D);
    do_op("lh",   1, 0, 3'b001, 32'h0000_0000, 32'h0,         5'd3,  0, 2, 2, 32'h0000_F234);
    do_op("lbu",  1, 0, 3'b100, 32'h0000_0003, 32'h0,         5'd31, 1, 0, 0, 32'h9A00_0000);
    do_op("nop",  0, 0, 3'b010, 32'h0000_7000, 32'h0,         5'd1,  1, 0, 0, 32'h0);
    do_op("ldst", 1, 1, 3'b010, 32'h0000_6000, 32'h5555_5555, 5'd12, 1, 0, 0, 32'h1357_9BDF);
    do_op("sw",   0, 1, 3'b010, 32'h0000_5000, 32'h0102_0304, 5'd0,  0, 0, 0, 32'h0);
    do_op("lw",   1, 0, 3'b010, 32'h0000_5004, 32'h0,         5'd20, 1, 1, 0, 32'h55AA_55AA);

    // Reset while waiting on a load response; the late rvalid must be ignored.
    begin
      req_t r;
      r.we = 1'b0; r.addr = 32'h0000_4000; r.be = 4'hF; r.wdata = '0;
      exp_req.push_back(r);
      gnt_dly = 0; rv_dly = 4; rd_word = 32'h7777_7777;
      exValid = 1'b1; loadSignal = 1'b1; storeSignal = 1'b0; loadStoreByteSelect = 3'b010;
      address = 32'h0000_4000; rdAddr = 5'd4; rdWriteEn = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("wait_req", dmem_bus.dmemReq, 0);
      chk("wait_stall", stall, 1);
      rst = 1'b1; exValid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("postrst_req", dmem_bus.dmemReq, 0);
      chk("postrst_stall", stall, 0);
      chk("postrst_wbvalid", wbValid, 0);
      chk("postrst_wbdata", wbData, 0);
      repeat (8) @(negedge clk);
      chk("late_rvalid_stall", stall, 0);
      chk("late_rvalid_wbdata", wbData, 0);
      @(posedge clk); #1;
    end
    do_op("lb_after_rst", 1, 0, 3'b000, 32'h0000_0102, 32'h0, 5'd6, 1, 0, 0, 32'h00FE_0000);

    repeat (3) @(posedge clk); #1;
    chk("req_left", exp_req.size(), 0);
    chk("wb_left", exp_wb.size(), 0);
    chk("fault_left", flt_n, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
